// File: rtl/clm_sub_bytes_tdm_if.sv
// Round-parameter bundle shared by every S-box lane of the CLM datapath.
interface params_if #(
  parameter int W = 16
);
  logic [W-1:0] tweak;

  modport in_use (input tweak);
endinterface

// File: rtl/clm_sub_bytes_tdm.sv
// Time-multiplexed masked Sub-bytes stage: NUM_SBOX clm_sbox lanes walk the
// 16 state bytes in 16/NUM_SBOX groups; result and randomness match 16 lanes.

// Fixed-latency masked S-box lane; the result is held until the next drdy_i.
module clm_sbox #(
  parameter int ELEM_W  = 16,
  parameter int RED_W   = 8,
  parameter int R_WORDS = 7,
  parameter int LAT     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  params_if.in_use                 params,
  input  logic                     drdy_i,
  input  logic [ELEM_W-1:0]        x,
  input  logic [R_WORDS*RED_W-1:0] r,
  output logic [ELEM_W-1:0]        y,
  output logic                     drdy_o
);
  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0]     r_cnt;
  logic [ELEM_W-1:0] r_y;
  logic [ELEM_W-1:0] w_fold;
  logic [ELEM_W-1:0] w_f;

  // Each randomness word lands at its own bit offset, so word order matters.
  always_comb begin
    w_fold = '0;
    for (int k = 0; k < R_WORDS; k++) begin
      w_fold = w_fold ^ (ELEM_W'(r[k*RED_W +: RED_W]) << (k % (ELEM_W - RED_W + 1)));
    end
  end

  assign w_f = {x[ELEM_W-4:0], x[ELEM_W-1:ELEM_W-3]} ^ w_fold ^ params.tweak ^ ELEM_W'(99);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_y   <= '0;
    end else if (drdy_i) begin
      r_cnt <= CW'(LAT);
      r_y   <= w_f;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign y      = r_y;
  assign drdy_o = (r_cnt == CW'(1));
endmodule

module clm_sub_bytes_tdm #(
  parameter int NUM_SBOX     = 4,
  parameter int ELEM_W       = 16,
  parameter int RED_W        = 8,
  parameter int R_WORDS      = 7,
  parameter int SBOX_LAT     = 3,
  parameter int SBOX_LAT_VAR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  params_if.in_use                 params,
  input  logic                     start,
  input  logic [16*ELEM_W-1:0]     in,
  input  logic                     load_r,
  input  logic [R_WORDS*RED_W-1:0] random_vect,
  output logic [16*ELEM_W-1:0]     out,
  output logic                     drdy_o,
  output logic                     busy
);
  localparam int RW    = R_WORDS * RED_W;
  localparam int G     = 16 / NUM_SBOX;
  localparam int GRP_W = (G > 1) ? $clog2(G) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
        NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
    $error("clm_sub_bytes_tdm: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  // Word k of the result is word (k+n) mod R_WORDS of v.
  function automatic logic [RW-1:0] shift_randomness(input logic [RW-1:0] v, input int n);
    logic [RW-1:0] res;
    for (int k = 0; k < R_WORDS; k++) begin
      res[k*RED_W +: RED_W] = v[((k + n) % R_WORDS)*RED_W +: RED_W];
    end
    return res;
  endfunction

  logic [1:0]           r_state;
  logic [GRP_W-1:0]     r_grp;
  logic [16*ELEM_W-1:0] r_in_buf;
  logic [16*ELEM_W-1:0] r_out_buf;
  logic [16*ELEM_W-1:0] r_out;
  logic [RW-1:0]        r_saved;
  logic [RW-1:0]        r_pending;
  logic                 r_pend_flag;
  logic [NUM_SBOX-1:0]  r_flag;

  logic                 w_drdy_i;
  logic [NUM_SBOX-1:0]  w_lane_drdy;
  logic [NUM_SBOX-1:0]  w_lane_ok;
  logic                 w_allrdy;
  logic                 w_last;
  logic [ELEM_W-1:0]    w_x [NUM_SBOX];
  logic [ELEM_W-1:0]    w_y [NUM_SBOX];
  logic [RW-1:0]        w_r [NUM_SBOX];
  logic [16*ELEM_W-1:0] w_merged;

  assign w_drdy_i = (r_state == ST_ISSUE) && !rst;

  for (genvar gi = 0; gi < NUM_SBOX; gi++) begin : g_lane
    assign w_x[gi] = r_in_buf[(int'(r_grp)*NUM_SBOX + gi)*ELEM_W +: ELEM_W];
    assign w_r[gi] = shift_randomness(r_saved, int'(r_grp)*NUM_SBOX + gi);

    clm_sbox #(
      .ELEM_W  (ELEM_W),
      .RED_W   (RED_W),
      .R_WORDS (R_WORDS),
      .LAT     (SBOX_LAT + ((SBOX_LAT_VAR != 0) ? (gi % 4) : 0))
    ) u_sbox (
      .clk    (clk),
      .rst    (rst),
      .params (params),
      .drdy_i (w_drdy_i),
      .x      (w_x[gi]),
      .r      (w_r[gi]),
      .y      (w_y[gi]),
      .drdy_o (w_lane_drdy[gi])
    );

    assign w_lane_ok[gi] = r_flag[gi] | w_lane_drdy[gi];
  end

  assign w_allrdy = &w_lane_ok;
  assign w_last   = (r_grp == GRP_W'(G - 1));

  // Group results overlaid on the buffer so the final group reaches out directly.
  always_comb begin
    w_merged = r_out_buf;
    for (int l = 0; l < NUM_SBOX; l++) begin
      w_merged[(int'(r_grp)*NUM_SBOX + l)*ELEM_W +: ELEM_W] = w_y[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grp       <= '0;
      r_in_buf    <= '0;
      r_out_buf   <= '0;
      r_out       <= '0;
      r_saved     <= '0;
      r_pending   <= '0;
      r_pend_flag <= 1'b0;
      r_flag      <= '0;
    end else begin
      if (load_r && (r_state == ST_ISSUE || r_state == ST_WAIT)) begin
        r_pending   <= random_vect;
        r_pend_flag <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (load_r) r_saved <= random_vect;
          if (start) begin
            r_in_buf <= in;
            r_grp    <= '0;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_flag  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_flag <= r_flag | w_lane_drdy;
          if (w_allrdy) begin
            r_out_buf <= w_merged;
            if (w_last) begin
              r_out   <= w_merged;
              r_state <= ST_DONE;
            end else begin
              r_grp   <= r_grp + GRP_W'(1);
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          // A load arriving in this very cycle is the most recent one.
          if (load_r)           r_saved <= random_vect;
          else if (r_pend_flag) r_saved <= r_pending;
          else                  r_saved <= shift_randomness(r_saved, 16);
          r_pend_flag <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out    = r_out;
  assign drdy_o = (r_state == ST_DONE);
  assign busy   = (r_state != ST_IDLE);
endmodule

// File: tb/tb_clm_sub_bytes_tdm.sv
// Directed bench for clm_sub_bytes_tdm: NUM_SBOX sweep, a staggered-latency
// variant, chained randomness passes, mid-pass load/start and mid-pass reset.
module tb_clm_sub_bytes_tdm;
  localparam int NDUT = 6;
  localparam int MAIN = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] in_st;
  logic         load_r;
  logic [55:0]  random_vect;
  logic [15:0]  tweak;
  logic [255:0] out_a  [NDUT];
  logic         drdy_a [NDUT];
  logic         busy_a [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  params_if #(.W(16)) u_params ();
  assign u_params.tweak = tweak;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int NS = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 :
                        (gi == 3) ? 8 : (gi == 4) ? 16 : 4;
    localparam int LT = (gi == 5) ? 2 : 3;
    localparam int LV = (gi == 5) ? 1 : 0;
    clm_sub_bytes_tdm #(
      .NUM_SBOX(NS), .ELEM_W(16), .RED_W(8), .R_WORDS(7),
      .SBOX_LAT(LT), .SBOX_LAT_VAR(LV)
    ) u_dut (
      .clk(clk), .rst(rst), .params(u_params), .start(start), .in(in_st),
      .load_r(load_r), .random_vect(random_vect),
      .out(out_a[gi]), .drdy_o(drdy_a[gi]), .busy(busy_a[gi])
    );
  end

  // Reference model: one S-box per byte, lane b fed shift_randomness(r, b).
  function automatic logic [55:0] m_shift(input logic [55:0] v, input int n);
    logic [55:0] res;
    for (int k = 0; k < 7; k++) res[k*8 +: 8] = v[((k + n) % 7)*8 +: 8];
    return res;
  endfunction

  function automatic logic [15:0] m_sbox(input logic [15:0] x, input logic [55:0] r,
                                         input logic [15:0] tw);
    logic [15:0] f;
    f = {x[12:0], x[15:13]} ^ tw ^ 16'h0063;
    for (int k = 0; k < 7; k++) f = f ^ ({8'h00, r[k*8 +: 8]} << k);
    return f;
  endfunction

  function automatic logic [255:0] m_golden(input logic [255:0] x, input logic [55:0] r,
                                            input logic [15:0] tw);
    logic [255:0] o;
    for (int b = 0; b < 16; b++) o[b*16 +: 16] = m_sbox(x[b*16 +: 16], m_shift(r, b), tw);
    return o;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pass on the main instance; input is scrambled once it has been sampled.
  task automatic run_pass(input logic ld, input logic [55:0] r, input logic [255:0] x,
                          output int cyc, output logic held, output logic busy_ok);
    logic [255:0] prev;
    prev    = out_a[MAIN];
    held    = 1'b1;
    busy_ok = 1'b1;
    cyc     = -1;
    load_r = ld; random_vect = r; start = 1'b1; in_st = x;
    for (int c = 1; c <= 60; c++) begin
      tick();
      load_r = 1'b0; start = 1'b0; in_st = ~x;
      if (!busy_a[MAIN]) busy_ok = 1'b0;
      if (drdy_a[MAIN]) begin
        cyc = c;
        break;
      end
      if (out_a[MAIN] !== prev) held = 1'b0;
    end
  endtask

  typedef struct {
    logic         do_load;
    logic [55:0]  r;
    logic [255:0] x;
    logic [15:0]  tw;
    logic [255:0] exp;
  } vec_t;

  localparam logic [55:0]  R0 = 56'h13579BDF2468AC;
  localparam logic [55:0]  R1 = 56'hF0E1D2C3B4A596;
  localparam logic [255:0] X0 = 256'h00112233445566778899AABBCCDDEEFF0123456789ABCDEFFEDCBA9876543210;
  localparam logic [255:0] X1 = 256'hDEADBEEFCAFEF00D0BADC0DE8BADF00D123400005678FFFF9ABC0000DEF01111;
  localparam logic [255:0] X2 = 256'hFFFF0000FFFF00008000000100020004AAAA5555A5A55A5AC3C33C3C0F0FF0F0;
  localparam logic [15:0]  T0 = 16'h1D2B;
  localparam logic [15:0]  T1 = 16'hE470;

  vec_t vt [4];

  initial begin
    int           cyc;
    int           pulses;
    int           first [NDUT];
    int           exp_cyc [NDUT];
    logic         held;
    logic         busy_ok;
    logic [55:0]  m_r;
    logic [255:0] zero;

    exp_cyc = '{65, 33, 17, 9, 5, 25};
    zero    = '0;

    // Passes 1 and 3 reload, passes 2 and 4 reuse the rotated randomness.
    vt[0] = '{1'b1, R0, X0, T0, '0};
    vt[1] = '{1'b0, '0, X1, T0, '0};
    vt[2] = '{1'b1, R1, X2, T1, '0};
    vt[3] = '{1'b0, '0, zero, T1, '0};
    m_r = '0;
    for (int v = 0; v < 4; v++) begin
      if (vt[v].do_load) m_r = vt[v].r;
      vt[v].exp = m_golden(vt[v].x, m_r, vt[v].tw);
      m_r = m_shift(m_r, 16);
    end

    rst = 1'b1; start = 1'b0; load_r = 1'b0; in_st = '0; random_vect = '0; tweak = T0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_out", out_a[MAIN], zero);
    chk_int("reset_busy", int'(busy_a[MAIN]), 0);
    chk_int("reset_drdy", int'(drdy_a[MAIN]), 0);

    // All configurations run the same pass side by side.
    for (int i = 0; i < NDUT; i++) first[i] = -1;
    load_r = 1'b1; random_vect = R0; start = 1'b1; in_st = X0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      load_r = 1'b0; start = 1'b0; in_st = X1;
      for (int i = 0; i < NDUT; i++) if (drdy_a[i] && first[i] < 0) first[i] = c;
    end
    for (int i = 0; i < NDUT; i++) begin
      chk_int($sformatf("sweep%0d_cycle", i), first[i], exp_cyc[i]);
      chk($sformatf("sweep%0d_out", i), out_a[i], m_golden(X0, R0, T0));
      $display("sweep dut%0d: drdy at cycle %0d", i, first[i]);
    end

    foreach (vt[v]) begin
      tweak = vt[v].tw;
      run_pass(vt[v].do_load, vt[v].r, vt[v].x, cyc, held, busy_ok);
      chk_int($sformatf("vec%0d_cycle", v), cyc, 17);
      chk($sformatf("vec%0d_out", v), out_a[MAIN], vt[v].exp);
      chk_int($sformatf("vec%0d_held", v), int'(held), 1);
      chk_int($sformatf("vec%0d_busy", v), int'(busy_ok), 1);
      tick();
      chk_int($sformatf("vec%0d_pulse_end", v), int'(drdy_a[MAIN]) + int'(busy_a[MAIN]), 0);
      $display("vec%0d: drdy at cycle %0d out=%h", v, cyc, out_a[MAIN]);
    end

    // load_r at cycle 6 and a stray start at cycle 8 of a pass.
    tweak = T0; first[MAIN] = -1; pulses = 0;
    load_r = 1'b1; random_vect = R0; start = 1'b1; in_st = X0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      load_r = 1'b0; start = 1'b0; in_st = X2;
      if (c == 6) begin load_r = 1'b1; random_vect = R1; end
      if (c == 8) start = 1'b1;
      if (drdy_a[MAIN]) begin
        pulses++;
        if (first[MAIN] < 0) first[MAIN] = c;
      end
    end
    chk_int("midload_cycle", first[MAIN], 17);
    chk_int("midload_pulses", pulses, 1);
    chk("midload_out", out_a[MAIN], m_golden(X0, R0, T0));
    chk_int("midload_idle", int'(busy_a[MAIN]), 0);
    run_pass(1'b0, '0, X1, cyc, held, busy_ok);
    chk_int("after_midload_cycle", cyc, 17);
    chk("after_midload_out", out_a[MAIN], m_golden(X1, R1, T0));
    $display("midload: drdy at cycle %0d, follow-up drdy at cycle %0d", first[MAIN], cyc);
    tick();

    // Reset at cycle 10 of a pass aborts it without a result pulse.
    pulses = 0;
    load_r = 1'b1; random_vect = R1; start = 1'b1; in_st = X2;
    for (int c = 1; c <= 40; c++) begin
      tick();
      load_r = 1'b0; start = 1'b0; rst = (c == 10);
      if (drdy_a[MAIN]) pulses++;
      if (c == 11) begin
        chk("rst_mid_out", out_a[MAIN], zero);
        chk_int("rst_mid_busy", int'(busy_a[MAIN]), 0);
      end
    end
    chk_int("rst_mid_pulses", pulses, 0);
    run_pass(1'b1, R0, X0, cyc, held, busy_ok);
    chk_int("after_rst_cycle", cyc, 17);
    chk("after_rst_out", out_a[MAIN], m_golden(X0, R0, T0));
    $display("midreset: %0d pulses during aborted pass, clean pass drdy at cycle %0d", pulses, cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
